// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control sequencer.
package lc3_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH0,
        FETCH1,
        FETCH2,
        DECODE,
        EX_ALU,
        EX_LEA,
        EX_BR,
        EX_JMP,
        ADDR,
        MEM_RD,
        WB,
        ST_DATA,
        ST_WR,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LEA,
        CLS_BR,
        CLS_JMP,
        CLS_LOAD,
        CLS_STORE,
        CLS_HALT
    } iclass_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_EAB = 2'b01;
    localparam logic [1:0] PC_BUS = 2'b10;

    localparam logic [1:0] EAB2_ZERO  = 2'b00;
    localparam logic [1:0] EAB2_OFF6  = 2'b01;
    localparam logic [1:0] EAB2_OFF9  = 2'b10;
    localparam logic [1:0] EAB2_OFF11 = 2'b11;

    localparam int unsigned MEM_WAIT_MAX = 7;

endpackage

// File: rtl/lc3_opdecode.sv
// Opcode classifier: maps IR[15:12] to an instruction class, base-register
// addressing flag (LDR/STR) and an unsupported-opcode flag.
module lc3_opdecode
    import lc3_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] cls,
    output logic       base_reg,
    output logic       illegal
);

    always_comb begin
        cls      = CLS_HALT;
        base_reg = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_ADD, OP_AND, OP_NOT: cls = CLS_ALU;
            OP_LEA:                 cls = CLS_LEA;
            OP_BR:                  cls = CLS_BR;
            OP_JMP:                 cls = CLS_JMP;
            OP_LD:                  cls = CLS_LOAD;
            OP_ST:                  cls = CLS_STORE;
            OP_LDR: begin
                cls      = CLS_LOAD;
                base_reg = 1'b1;
            end
            OP_STR: begin
                cls      = CLS_STORE;
                base_reg = 1'b1;
            end
            OP_TRAP:                cls = CLS_HALT;
            default:                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lc3_sequencer.sv
// Multi-cycle LC-3 control FSM: fetch/decode/execute sequencing with
// memory wait states, retired-instruction counter and sticky illegal flag.
module lc3_sequencer
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    output logic [1:0]  aluControl,
    output logic        enaALU,
    output logic        enaMARM,
    output logic        enaMDR,
    output logic        enaPC,
    output logic        selMAR,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        ldPC,
    output logic        ldIR,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic [1:0]  selPC,
    output logic        selMDR,
    output logic [2:0]  SR0,
    output logic [2:0]  SR1,
    output logic [2:0]  DR,
    output logic        regWE,
    output logic        memWE,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam int unsigned WAIT_EFF = (MEM_WAIT > MEM_WAIT_MAX) ? MEM_WAIT_MAX : MEM_WAIT;
    localparam logic [2:0]  WAIT_LIM = 3'(WAIT_EFF);

    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [15:0] count_q, count_d;
    logic        illegal_q, illegal_d;

    logic [2:0]  dec_cls;
    iclass_t     cls;
    logic        base_reg;
    logic        dec_illegal;
    logic        wait_done;
    logic        retire;
    logic        unused_ir;

    lc3_opdecode u_opdecode (
        .opcode   (IR[15:12]),
        .cls      (dec_cls),
        .base_reg (base_reg),
        .illegal  (dec_illegal)
    );

    assign cls         = iclass_t'(dec_cls);
    assign wait_done   = (wait_q == WAIT_LIM);
    assign instr_count = count_q;
    assign illegal     = illegal_q;
    assign unused_ir   = ^IR[5:3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        aluControl = ALU_ADD;
        enaALU     = 1'b0;
        enaMARM    = 1'b0;
        enaMDR     = 1'b0;
        enaPC      = 1'b0;
        selMAR     = 1'b0;
        selEAB1    = 1'b0;
        selEAB2    = EAB2_ZERO;
        ldPC       = 1'b0;
        ldIR       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        selPC      = PC_INC;
        selMDR     = 1'b0;
        SR0        = '0;
        SR1        = '0;
        DR         = '0;
        regWE      = 1'b0;
        memWE      = 1'b0;
        halted     = 1'b0;
        state_d    = state_q;
        wait_d     = '0;
        count_d    = count_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH0;
            end
            FETCH0: begin
                enaPC   = 1'b1;
                ldMAR   = 1'b1;
                ldPC    = 1'b1;
                selPC   = PC_INC;
                state_d = FETCH1;
            end
            FETCH1: begin
                ldMDR  = 1'b1;
                selMDR = 1'b1;
                if (wait_done) state_d = FETCH2;
                else           wait_d  = wait_q + 3'd1;
            end
            FETCH2: begin
                enaMDR  = 1'b1;
                ldIR    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                case (cls)
                    CLS_ALU:   state_d = EX_ALU;
                    CLS_LEA:   state_d = EX_LEA;
                    CLS_BR:    state_d = EX_BR;
                    CLS_JMP:   state_d = EX_JMP;
                    CLS_LOAD,
                    CLS_STORE: state_d = ADDR;
                    default: begin
                        state_d   = HALT;
                        illegal_d = illegal_q | dec_illegal;
                    end
                endcase
            end
            EX_ALU: begin
                enaALU = 1'b1;
                regWE  = 1'b1;
                DR     = IR[11:9];
                SR0    = IR[8:6];
                SR1    = IR[2:0];
                case (IR[15:12])
                    OP_AND:  aluControl = ALU_AND;
                    OP_NOT:  aluControl = ALU_NOT;
                    default: aluControl = ALU_ADD;
                endcase
                retire = 1'b1;
            end
            EX_LEA: begin
                enaMARM = 1'b1;
                selEAB2 = EAB2_OFF9;
                regWE   = 1'b1;
                DR      = IR[11:9];
                retire  = 1'b1;
            end
            EX_BR: begin
                ldPC    = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
                selPC   = PC_EAB;
                selEAB2 = EAB2_OFF9;
                retire  = 1'b1;
            end
            EX_JMP: begin
                ldPC    = 1'b1;
                selPC   = PC_EAB;
                selEAB1 = 1'b1;
                selEAB2 = EAB2_ZERO;
                SR0     = IR[8:6];
                retire  = 1'b1;
            end
            ADDR: begin
                enaMARM = 1'b1;
                ldMAR   = 1'b1;
                if (base_reg) begin
                    selEAB1 = 1'b1;
                    selEAB2 = EAB2_OFF6;
                    SR0     = IR[8:6];
                end else begin
                    selEAB2 = EAB2_OFF9;
                end
                state_d = (cls == CLS_STORE) ? ST_DATA : MEM_RD;
            end
            MEM_RD: begin
                ldMDR  = 1'b1;
                selMDR = 1'b1;
                if (wait_done) state_d = WB;
                else           wait_d  = wait_q + 3'd1;
            end
            WB: begin
                enaMDR = 1'b1;
                regWE  = 1'b1;
                DR     = IR[11:9];
                retire = 1'b1;
            end
            ST_DATA: begin
                SR0        = IR[11:9];
                enaALU     = 1'b1;
                aluControl = ALU_PASS;
                ldMDR      = 1'b1;
                state_d    = ST_WR;
            end
            ST_WR: begin
                memWE = 1'b1;
                if (wait_done) retire = 1'b1;
                else           wait_d = wait_q + 3'd1;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // run is only looked at here and in IDLE, so a mid-instruction drop still completes it
        if (retire) begin
            count_d = count_q + 16'd1;
            state_d = run ? FETCH0 : IDLE;
        end
    end

endmodule

// File: tb/tb_lc3_sequencer.sv
// Bench for lc3_sequencer: two instances (MEM_WAIT 0 and 2) checked cycle by
// cycle against per-instruction control sequences built from the ISA rules.
module tb_lc3_sequencer;
    import lc3_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] alu;
        logic       enaALU;
        logic       enaMARM;
        logic       enaMDR;
        logic       enaPC;
        logic       selMAR;
        logic       selEAB1;
        logic [1:0] selEAB2;
        logic       ldPC;
        logic       ldIR;
        logic       ldMAR;
        logic       ldMDR;
        logic [1:0] selPC;
        logic       selMDR;
        logic [2:0] SR0;
        logic [2:0] SR1;
        logic [2:0] DR;
        logic       regWE;
        logic       memWE;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        int          d;
        logic [15:0] ir;
        logic [2:0]  nzp;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n [2];
    logic        run_r [2];
    logic [15:0] ir_r  [2];
    logic        n_r   [2];
    logic        z_r   [2];
    logic        p_r   [2];
    ctrl_t       act   [2];
    logic [15:0] cnt   [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_cnt [2];
    logic        model_ill [2];
    bit          at_f0     [2];
    ctrl_t       exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [1:0] aluControl, selEAB2, selPC;
        logic       enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1;
        logic       ldPC, ldIR, ldMAR, ldMDR, selMDR, regWE, memWE, halted, illegal;
        logic [2:0] SR0, SR1, DR;
        logic [15:0] instr_count;

        lc3_sequencer #(.MEM_WAIT(g * 2)) u_dut (
            .clk(clk), .reset(rst_n[g]), .run(run_r[g]), .IR(ir_r[g]),
            .N(n_r[g]), .Z(z_r[g]), .P(p_r[g]),
            .aluControl(aluControl), .enaALU(enaALU), .enaMARM(enaMARM),
            .enaMDR(enaMDR), .enaPC(enaPC), .selMAR(selMAR), .selEAB1(selEAB1),
            .selEAB2(selEAB2), .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR),
            .ldMDR(ldMDR), .selPC(selPC), .selMDR(selMDR), .SR0(SR0), .SR1(SR1),
            .DR(DR), .regWE(regWE), .memWE(memWE), .halted(halted),
            .illegal(illegal), .instr_count(instr_count)
        );

        assign act[g] = {aluControl, enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1,
                         selEAB2, ldPC, ldIR, ldMAR, ldMDR, selPC, selMDR, SR0, SR1, DR,
                         regWE, memWE, halted, illegal};
        assign cnt[g] = instr_count;
    end

    function automatic ctrl_t fetch0_ctrl();
        ctrl_t c = '0;
        c.enaPC = 1'b1; c.ldMAR = 1'b1; c.ldPC = 1'b1;
        return c;
    endfunction

    // Expected per-cycle controls from FETCH0 up to the retire cycle (or DECODE for halts)
    function automatic void build(input logic [15:0] ir, input logic [2:0] nzp,
                                  input int mw, output bit halts, output bit ill);
        ctrl_t c;
        logic [3:0] op = ir[15:12];
        exp_q.delete();
        halts = 1'b0;
        ill   = 1'b0;
        exp_q.push_back(fetch0_ctrl());
        c = '0; c.ldMDR = 1'b1; c.selMDR = 1'b1;
        for (int i = 0; i <= mw; i++) exp_q.push_back(c);
        c = '0; c.enaMDR = 1'b1; c.ldIR = 1'b1;
        exp_q.push_back(c);
        exp_q.push_back('0);
        c = '0;
        if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
            c.enaALU = 1'b1; c.regWE = 1'b1;
            c.DR = ir[11:9]; c.SR0 = ir[8:6]; c.SR1 = ir[2:0];
            c.alu = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
            exp_q.push_back(c);
        end else if (op == 4'hE) begin
            c.enaMARM = 1'b1; c.selEAB2 = 2'd2; c.regWE = 1'b1; c.DR = ir[11:9];
            exp_q.push_back(c);
        end else if (op == 4'h0) begin
            c.ldPC = (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);
            c.selPC = 2'd1; c.selEAB2 = 2'd2;
            exp_q.push_back(c);
        end else if (op == 4'hC) begin
            c.ldPC = 1'b1; c.selPC = 2'd1; c.selEAB1 = 1'b1; c.SR0 = ir[8:6];
            exp_q.push_back(c);
        end else if (op == 4'h2 || op == 4'h3 || op == 4'h6 || op == 4'h7) begin
            c.enaMARM = 1'b1; c.ldMAR = 1'b1;
            if (op == 4'h6 || op == 4'h7) begin
                c.selEAB1 = 1'b1; c.selEAB2 = 2'd1; c.SR0 = ir[8:6];
            end else begin
                c.selEAB2 = 2'd2;
            end
            exp_q.push_back(c);
            if (op == 4'h2 || op == 4'h6) begin
                c = '0; c.ldMDR = 1'b1; c.selMDR = 1'b1;
                for (int i = 0; i <= mw; i++) exp_q.push_back(c);
                c = '0; c.enaMDR = 1'b1; c.regWE = 1'b1; c.DR = ir[11:9];
                exp_q.push_back(c);
            end else begin
                c = '0; c.SR0 = ir[11:9]; c.enaALU = 1'b1; c.alu = 2'd3; c.ldMDR = 1'b1;
                exp_q.push_back(c);
                c = '0; c.memWE = 1'b1;
                for (int i = 0; i <= mw; i++) exp_q.push_back(c);
            end
        end else begin
            halts = 1'b1;
            ill   = (op != 4'hF);
        end
    endfunction

    task automatic check_ctrl(input int d, input string nm, input int step, input ctrl_t want);
        n_tests++;
        if (act[d] !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d step%0d: ctrl got %h want %h", nm, d, step, act[d], want);
        end
    endtask

    task automatic check_cnt(input int d, input string nm, input logic [15:0] want);
        n_tests++;
        if (cnt[d] !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d: instr_count got %h want %h", nm, d, cnt[d], want);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        run_r[d] = 1'b0;
        #1;
        check_ctrl(d, "reset_ctrl", 0, '0);
        check_cnt(d, "reset_cnt", 16'h0000);
        model_cnt[d] = '0;
        model_ill[d] = 1'b0;
        at_f0[d]     = 1'b0;
        @(negedge clk);
        rst_n[d] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction; lat = samples from FETCH0 until instr_count moves
    task automatic exec(input int d, input logic [15:0] ir, input logic [2:0] nzp,
                        input bit keep_run, output int lat);
        bit          halts, ill;
        ctrl_t       c;
        logic [15:0] start_cnt = model_cnt[d];
        build(ir, nzp, d * 2, halts, ill);
        ir_r[d] = ir;
        {n_r[d], z_r[d], p_r[d]} = nzp;
        if (!at_f0[d]) begin
            run_r[d] = 1'b1;
            @(posedge clk);
            #1;
        end
        run_r[d] = keep_run;
        lat = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check_ctrl(d, "seq", k, exp_q[k]);
            if (lat < 0 && cnt[d] !== start_cnt) lat = k;
        end
        @(posedge clk);
        #1;
        if (halts) begin
            model_ill[d] = ill;
            run_r[d] = 1'b1;
            c = '0; c.halted = 1'b1; c.illegal = ill;
            for (int k = 0; k < 3; k++) begin
                check_ctrl(d, "halt", k, c);
                @(posedge clk);
                #1;
            end
            check_cnt(d, "halt_cnt", start_cnt);
            at_f0[d] = 1'b0;
            lat = 0;
        end else begin
            model_cnt[d] = model_cnt[d] + 16'd1;
            if (lat < 0 && cnt[d] !== start_cnt) lat = exp_q.size();
            check_ctrl(d, "post", 0, keep_run ? fetch0_ctrl() : ctrl_t'('0));
            check_cnt(d, "retire_cnt", model_cnt[d]);
            at_f0[d] = keep_run;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [$];
        int          lat;
        int          d, nd;
        bit          seen;
        logic [3:0]  ops [10] = '{4'h1, 4'h5, 4'h9, 4'hE, 4'h0, 4'hC, 4'h2, 4'h6, 4'h3, 4'h7};

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; run_r[i] = 1'b0; ir_r[i] = '0;
            n_r[i] = 1'b0; z_r[i] = 1'b0; p_r[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) do_reset(i);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_ctrl(i, "idle", 0, '0);
            check_cnt(i, "idle_cnt", 16'h0000);
        end

        vecs.push_back('{0, 16'h1283, 3'b000, 5});
        vecs.push_back('{0, 16'h0A05, 3'b010, 5});
        vecs.push_back('{0, 16'h0A05, 3'b100, 5});
        vecs.push_back('{1, 16'h6642, 3'b001, 11});
        vecs.push_back('{0, 16'h7442, 3'b000, 0});
        vecs.push_back('{0, 16'hE3F0, 3'b000, 5});
        vecs.push_back('{0, 16'hC1C0, 3'b000, 5});
        vecs.push_back('{0, 16'h2A10, 3'b000, 7});
        vecs.push_back('{0, 16'h927F, 3'b000, 5});
        vecs.push_back('{1, 16'h1283, 3'b000, 7});
        vecs.push_back('{1, 16'h0E00, 3'b001, 7});
        vecs.push_back('{0, 16'hD000, 3'b000, 0});
        vecs.push_back('{0, 16'hF025, 3'b000, 0});
        vecs.push_back('{1, 16'h4000, 3'b000, 0});
        foreach (vecs[i]) begin
            exec(vecs[i].d, vecs[i].ir, vecs[i].nzp, 1'b0, lat);
            if (vecs[i].lat != 0) check_int($sformatf("latency_%h", vecs[i].ir), lat, vecs[i].lat);
            if (act[vecs[i].d].halted) do_reset(vecs[i].d);
        end

        exec(0, 16'h1283, 3'b000, 1'b1, lat);
        exec(0, 16'h6642, 3'b000, 1'b1, lat);
        exec(0, 16'h0E00, 3'b010, 1'b0, lat);

        d = int'($urandom_range(0, 1));
        for (int it = 0; it < 60; it++) begin
            nd = int'($urandom_range(0, 1));
            exec(d, {ops[$urandom_range(0, 9)], 12'($urandom)}, 3'($urandom),
                 ($urandom_range(0, 1) == 1) && (nd == d), lat);
            d = nd;
        end
        for (int i = 0; i < 2; i++) begin
            if (at_f0[i]) exec(i, 16'h1283, 3'b000, 1'b0, lat);
        end

        ir_r[1] = 16'h7442;
        run_r[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (act[1].memWE) seen = 1'b1;
        end
        check_int("reach_st_wr", int'(seen), 1);
        rst_n[1] = 1'b0;
        #1;
        check_ctrl(1, "rst_mid_stwr", 0, '0);
        check_cnt(1, "rst_mid_stwr_cnt", 16'h0000);
        run_r[1] = 1'b1;
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        check_ctrl(1, "fetch0_after_rst", 0, fetch0_ctrl());
        do_reset(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
